input_cmd_arbiter: RTL and testbench

- Merges the two game-input sources into one ordered command stream for game_control / input_manager:
  - PS/2 key events (game_clk domain, after CDC);
  - debounced board buttons.
- Decodes scan codes and detects button edges, then arbitrates the two sources round-robin into a small command FIFO.
- Presents the FIFO output on a valid/ready interface.
- Also maintains authoritative held-level state per command, combining keyboard and buttons.

---
 rtl/input_cmd_arbiter_pkg.sv | 76 +++++++
 rtl/input_cmd_arbiter_if.sv | 21 ++
 rtl/input_cmd_arbiter_cmd_fifo.sv | 71 +++++++
 rtl/input_cmd_arbiter.sv | 157 +++++++++++++++
 tb/tb_input_cmd_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/input_cmd_arbiter_pkg.sv
// Shared types and constants for the input command arbiter.
// Provides cmd_t encoding, button bit indices, PS/2 set-2 scan codes,
// FIFO payload struct and the keyboard/button decode helpers.
package input_cmd_arbiter_pkg;

  typedef enum logic [2:0] {
    CMD_LEFT    = 3'd0,
    CMD_RIGHT   = 3'd1,
    CMD_DOWN    = 3'd2,
    CMD_ROT_CW  = 3'd3,
    CMD_ROT_CCW = 3'd4,
    CMD_DROP    = 3'd5,
    CMD_HOLD    = 3'd6
  } cmd_t;

  localparam int unsigned CMD_COUNT = 7;
  localparam int unsigned BTN_COUNT = 5;

  localparam int unsigned BTN_L = 0;
  localparam int unsigned BTN_R = 1;
  localparam int unsigned BTN_U = 2;
  localparam int unsigned BTN_D = 3;
  localparam int unsigned BTN_C = 4;

  // Set-2 codes; extended arrows are identified by their final byte.
  localparam logic [7:0] SC_LEFT_ARROW  = 8'h6B;
  localparam logic [7:0] SC_RIGHT_ARROW = 8'h74;
  localparam logic [7:0] SC_DOWN_ARROW  = 8'h72;
  localparam logic [7:0] SC_UP_ARROW    = 8'h75;
  localparam logic [7:0] SC_X           = 8'h22;
  localparam logic [7:0] SC_Z           = 8'h1A;
  localparam logic [7:0] SC_SPACE       = 8'h29;
  localparam logic [7:0] SC_LSHIFT      = 8'h12;

  // Command FIFO payload
  typedef struct packed {
    logic press;
    cmd_t code;
  } cmd_entry_t;

  typedef struct packed {
    logic hit;
    cmd_t code;
  } kb_dec_t;

  // Scan code to command; hit=0 for codes the game ignores
  function automatic kb_dec_t decode_scan(input logic [7:0] sc);
    kb_dec_t r;
    r.hit  = 1'b1;
    r.code = CMD_LEFT;
    case (sc)
      SC_LEFT_ARROW:  r.code = CMD_LEFT;
      SC_RIGHT_ARROW: r.code = CMD_RIGHT;
      SC_DOWN_ARROW:  r.code = CMD_DOWN;
      SC_UP_ARROW:    r.code = CMD_ROT_CW;
      SC_X:           r.code = CMD_ROT_CW;
      SC_Z:           r.code = CMD_ROT_CCW;
      SC_SPACE:       r.code = CMD_DROP;
      SC_LSHIFT:      r.code = CMD_HOLD;
      default:        r.hit  = 1'b0;
    endcase
    return r;
  endfunction

  // Button bit index to command
  function automatic cmd_t btn_to_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return CMD_LEFT;
      3'd1:    return CMD_RIGHT;
      3'd2:    return CMD_ROT_CW;
      3'd3:    return CMD_DOWN;
      default: return CMD_DROP;
    endcase
  endfunction

endpackage

// File: rtl/input_cmd_arbiter_if.sv
// Key-event input and command valid/ready output bundle.
// master: keyboard/consumer side; slave: the arbiter.
interface input_cmd_arbiter_if;
  logic       kb_valid;
  logic [7:0] kb_scan_code;
  logic       kb_make;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_code;
  logic       cmd_press;

  modport master (
    output kb_valid, kb_scan_code, kb_make, cmd_ready,
    input  cmd_valid, cmd_code, cmd_press
  );

  modport slave (
    input  kb_valid, kb_scan_code, kb_make, cmd_ready,
    output cmd_valid, cmd_code, cmd_press
  );
endinterface

// File: rtl/input_cmd_arbiter_cmd_fifo.sv
// cmd_fifo: synchronous show-ahead FIFO with a registered head payload.
// Ports: clk, rst_n (sync, active-low), flush, push/push_data, pop,
// out_valid/out_data (head), full, level (occupancy).
module cmd_fifo
  import input_cmd_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  cmd_entry_t               push_data,
  input  logic                     pop,
  output logic                     out_valid,
  output cmd_entry_t               out_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  cmd_entry_t          mem_q [DEPTH];
  cmd_entry_t          mem_d [DEPTH];
  logic [AW-1:0]       rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0]       cnt_q, cnt_d;
  cmd_entry_t          head_q, head_d;
  logic                valid_q, valid_d;
  logic                do_push, do_pop;

  // Next pointers/count; head is re-read from the post-update storage
  always_comb begin
    do_pop  = pop & valid_q;
    do_push = push & ((cnt_q != LW'(DEPTH)) | do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = push_data;
    rd_d  = rd_q + AW'(do_pop);
    wr_d  = wr_q + AW'(do_push);
    cnt_d = cnt_q + LW'(do_push) - LW'(do_pop);
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
    head_d  = mem_d[rd_d];
    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = head_q;
  assign full      = (cnt_q == LW'(DEPTH));
  assign level     = cnt_q;
endmodule

// File: rtl/input_cmd_arbiter.sv
// input_cmd_arbiter: merges decoded PS/2 key events and board-button edges
// round-robin into a command FIFO, and tracks held level per command.
// Ports: clk, rst_n (sync, active-low), flush, bus (kb_* in, cmd_* out),
// btn_level, held_out, drop_count, fifo_level.
module input_cmd_arbiter
  import input_cmd_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input_cmd_arbiter_if.slave            bus,
  input  logic [BTN_COUNT-1:0]          btn_level,
  output logic [CMD_COUNT-1:0]          held_out,
  output logic [DROP_CNT_W-1:0]         drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int unsigned SUM_W = DROP_CNT_W + 1;

  logic                  kb_pend_v_q, kb_pend_v_d;
  cmd_entry_t            kb_pend_q, kb_pend_d;
  logic [BTN_COUNT-1:0]  btn_q, btn_d;
  logic [BTN_COUNT-1:0]  btn_pend_q, btn_pend_d;
  logic [BTN_COUNT-1:0]  btn_pol_q, btn_pol_d;
  logic                  rr_last_q, rr_last_d;
  logic [CMD_COUNT-1:0]  kb_held_q, kb_held_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  kb_dec_t               dec;
  logic                  kb_evt, btn_any, grant_kb, grant_btn, enq_ok, push, deq;
  logic [BTN_COUNT-1:0]  btn_edge, btn_drain;
  logic [2:0]            btn_sel, n_drop;
  logic [SUM_W-1:0]      drop_sum;
  cmd_entry_t            push_data, fifo_head;
  logic                  fifo_valid, fifo_full;
  logic [CMD_COUNT-1:0]  held_btn;

  // Round-robin pick between kb_pend and the lowest pending button
  always_comb begin
    btn_sel = '0;
    for (int i = int'(BTN_COUNT) - 1; i >= 0; i--) begin
      if (btn_pend_q[i]) btn_sel = 3'(i);
    end
    btn_any   = |btn_pend_q;
    deq       = fifo_valid & bus.cmd_ready;
    enq_ok    = ~fifo_full | deq;
    grant_kb  = kb_pend_v_q & (~btn_any | ~rr_last_q);
    grant_btn = btn_any & ~grant_kb;
    push      = enq_ok & (grant_kb | grant_btn) & ~flush;
    push_data.press = btn_pol_q[btn_sel];
    push_data.code  = btn_to_cmd(btn_sel);
    if (grant_kb) push_data = kb_pend_q;
    btn_drain = '0;
    if (push & grant_btn) btn_drain[btn_sel] = 1'b1;
  end

  // Event capture, drop accounting and flush
  always_comb begin
    dec         = decode_scan(bus.kb_scan_code);
    kb_evt      = bus.kb_valid & dec.hit;
    btn_edge    = btn_level ^ btn_q;
    btn_d       = btn_level;
    kb_held_d   = kb_held_q;
    kb_pend_d   = kb_pend_q;
    kb_pend_v_d = kb_pend_v_q & ~(push & grant_kb);
    btn_pend_d  = btn_pend_q & ~btn_drain;
    btn_pol_d   = btn_pol_q;
    rr_last_d   = push ? grant_kb : rr_last_q;
    n_drop      = '0;

    // Held level tracks every mapped key even when the event is dropped
    if (kb_evt) kb_held_d[dec.code] = bus.kb_make;

    if (kb_evt) begin
      if (kb_pend_v_d) begin
        n_drop = n_drop + 3'd1;
      end else begin
        kb_pend_v_d     = 1'b1;
        kb_pend_d.press = bus.kb_make;
        kb_pend_d.code  = dec.code;
      end
    end

    for (int i = 0; i < int'(BTN_COUNT); i++) begin
      if (btn_edge[i]) begin
        if (btn_pend_d[i]) begin
          n_drop = n_drop + 3'd1;
        end else begin
          btn_pend_d[i] = 1'b1;
          btn_pol_d[i]  = btn_level[i];
        end
      end
    end

    if (flush) begin
      kb_pend_v_d = 1'b0;
      btn_pend_d  = '0;
      n_drop      = '0;
    end

    drop_sum = {1'b0, drop_q} + SUM_W'(n_drop);
    drop_d   = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kb_pend_v_q <= 1'b0;
      kb_pend_q   <= '0;
      btn_q       <= '0;
      btn_pend_q  <= '0;
      btn_pol_q   <= '0;
      rr_last_q   <= 1'b0;
      kb_held_q   <= '0;
      drop_q      <= '0;
    end else begin
      kb_pend_v_q <= kb_pend_v_d;
      kb_pend_q   <= kb_pend_d;
      btn_q       <= btn_d;
      btn_pend_q  <= btn_pend_d;
      btn_pol_q   <= btn_pol_d;
      rr_last_q   <= rr_last_d;
      kb_held_q   <= kb_held_d;
      drop_q      <= drop_d;
    end
  end

  // Button contribution to held level
  always_comb begin
    held_btn              = '0;
    held_btn[CMD_LEFT]    = btn_level[BTN_L];
    held_btn[CMD_RIGHT]   = btn_level[BTN_R];
    held_btn[CMD_ROT_CW]  = btn_level[BTN_U];
    held_btn[CMD_DOWN]    = btn_level[BTN_D];
    held_btn[CMD_DROP]    = btn_level[BTN_C];
  end

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (deq),
    .out_valid (fifo_valid),
    .out_data  (fifo_head),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  assign bus.cmd_valid = fifo_valid;
  assign bus.cmd_code  = fifo_head.code;
  assign bus.cmd_press = fifo_head.press;
  assign held_out      = kb_held_q | held_btn;
  assign drop_count    = drop_q;
endmodule

// File: tb/tb_input_cmd_arbiter.sv
// Bench for input_cmd_arbiter: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_input_cmd_arbiter;
  localparam int unsigned DEPTH = 8;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [4:0] btn_level;
  logic [6:0] held_out;
  logic [7:0] drop_count;
  logic [3:0] fifo_level;

  input_cmd_arbiter_if bus();

  input_cmd_arbiter #(.FIFO_DEPTH(DEPTH), .DROP_CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus),
    .btn_level  (btn_level),
    .held_out   (held_out),
    .drop_count (drop_count),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: {press, code} entries
  logic [3:0] m_fifo[$];
  logic [3:0] m_kb[$];
  logic [4:0] m_bp, m_bpol, m_prev;
  bit         m_kb_last;
  logic [6:0] m_held;
  int         m_drops;

  logic [3:0] got_q[$];
  bit         obs_valid;
  logic [3:0] obs_head;

  logic [7:0] kcodes [8]  = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h22, 8'h1A, 8'h29, 8'h12};
  logic [7:0] acodes [10] = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h22, 8'h1A, 8'h29, 8'h12, 8'h1C, 8'h55};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int map_scan(input logic [7:0] sc);
    case (sc)
      8'h6B: return 0;
      8'h74: return 1;
      8'h72: return 2;
      8'h75, 8'h22: return 3;
      8'h1A: return 4;
      8'h29: return 5;
      8'h12: return 6;
      default: return -1;
    endcase
  endfunction

  function automatic int btn_cmd(input int i);
    case (i)
      0: return 0;
      1: return 1;
      2: return 3;
      3: return 2;
      default: return 5;
    endcase
  endfunction

  function automatic logic [6:0] btn_held(input logic [4:0] b);
    logic [6:0] r = '0;
    for (int i = 0; i < 5; i++) if (b[i]) r[btn_cmd(i)] = 1'b1;
    return r;
  endfunction

  task automatic add_drop();
    if (m_drops < 255) m_drops++;
  endtask

  // One clock edge of the intended behaviour
  task automatic model_step();
    int mc;
    int bi;
    if (!rst_n) begin
      m_fifo.delete(); m_kb.delete();
      m_bp = '0; m_bpol = '0; m_prev = '0; m_kb_last = 0; m_held = '0; m_drops = 0;
      return;
    end
    mc = bus.kb_valid ? map_scan(bus.kb_scan_code) : -1;
    if (mc >= 0) m_held[mc] = bus.kb_make;
    if (flush) begin
      m_fifo.delete(); m_kb.delete(); m_bp = '0; m_prev = btn_level;
      return;
    end
    if (m_fifo.size() > 0 && bus.cmd_ready) void'(m_fifo.pop_front());
    bi = -1;
    for (int i = 4; i >= 0; i--) if (m_bp[i]) bi = i;
    if (m_fifo.size() < int'(DEPTH)) begin
      if (m_kb.size() > 0 && (bi < 0 || !m_kb_last)) begin
        m_fifo.push_back(m_kb.pop_front());
        m_kb_last = 1;
      end else if (bi >= 0) begin
        m_fifo.push_back({m_bpol[bi], 3'(btn_cmd(bi))});
        m_bp[bi] = 1'b0;
        m_kb_last = 0;
      end
    end
    if (mc >= 0) begin
      if (m_kb.size() > 0) add_drop();
      else m_kb.push_back({bus.kb_make, 3'(mc)});
    end
    for (int i = 0; i < 5; i++) begin
      if (btn_level[i] != m_prev[i]) begin
        if (m_bp[i]) add_drop();
        else begin m_bp[i] = 1'b1; m_bpol[i] = btn_level[i]; end
      end
    end
    m_prev = btn_level;
  endtask

  task automatic check_outputs();
    chk("cmd_valid", 32'(bus.cmd_valid), 32'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) chk("cmd_head", 32'({bus.cmd_press, bus.cmd_code}), 32'(m_fifo[0]));
    chk("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
    chk("held_out", 32'(held_out), 32'(m_held | btn_held(btn_level)));
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    obs_valid = bus.cmd_valid;
    obs_head  = {bus.cmd_press, bus.cmd_code};
    if (bus.cmd_valid && bus.cmd_ready) got_q.push_back(obs_head);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic key(input logic [7:0] sc, input logic mk);
    bus.kb_valid = 1'b1; bus.kb_scan_code = sc; bus.kb_make = mk;
    cycle();
    bus.kb_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin cycle(); lat++; end while (!obs_valid && lat < 20);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.kb_valid = 1'b0; flush = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    int d0;
    logic [6:0] h0;
    bit any_valid;
    logic [3:0] exp3 [3] = '{4'hD, 4'h8, 4'h9};

    rst_n = 1'b0; flush = 1'b0; btn_level = '0;
    bus.kb_valid = 1'b0; bus.kb_scan_code = '0; bus.kb_make = 1'b0; bus.cmd_ready = 1'b1;
    @(posedge clk); model_step(); #1;
    cycle();
    chk("rst_valid", 32'(bus.cmd_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_held", 32'(held_out), 32'd0);
    rst_n = 1'b1;

    // LEFT make: 2-cycle latency
    key(8'h6B, 1'b1);
    wait_valid(lat);
    chk("left_lat", 32'(lat), 32'd2);
    chk("left_head", 32'(obs_head), 32'h8);
    chk("left_held", 32'(held_out), 32'h01);
    repeat (2) cycle();
    chk("left_level", 32'(fifo_level), 32'd0);
    key(8'h6B, 1'b0);
    repeat (4) cycle();

    // SPACE with two button presses in the same cycle
    do_reset();
    got_q.delete();
    bus.kb_valid = 1'b1; bus.kb_scan_code = 8'h29; bus.kb_make = 1'b1; btn_level = 5'b00011;
    cycle();
    bus.kb_valid = 1'b0;
    repeat (6) cycle();
    chk("mix_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("mix_order", 32'((i < got_q.size()) ? got_q[i] : 4'hF), 32'(exp3[i]));
    btn_level = '0;
    repeat (6) cycle();

    // Backpressure: fill FIFO and both pending stages, then overflow kb
    bus.cmd_ready = 1'b0;
    for (int i = 0; i < 9; i++) key(kcodes[i % 8], 1'(i % 2));
    btn_level[2] = 1'b1;
    cycle();
    chk("ovf_level", 32'(fifo_level), 32'd8);
    chk("ovf_drop0", 32'(drop_count), 32'd0);
    key(8'h12, 1'b1);
    chk("ovf_drop1", 32'(drop_count), 32'd1);
    bus.cmd_ready = 1'b1;
    repeat (16) cycle();
    btn_level = '0;
    repeat (4) cycle();

    // Unmapped scan code
    d0 = m_drops; h0 = m_held | btn_held(btn_level); any_valid = 0;
    key(8'h1C, 1'b1);
    repeat (4) begin cycle(); any_valid |= obs_valid; end
    chk("unm_valid", 32'(any_valid), 32'd0);
    chk("unm_drop", 32'(drop_count), 32'(d0));
    chk("unm_held", 32'(held_out), 32'(h0));

    // Flush clears the queue but keeps held state
    key(8'h1A, 1'b1);
    repeat (4) cycle();
    bus.cmd_ready = 1'b0;
    key(8'h6B, 1'b1); key(8'h74, 1'b1); key(8'h72, 1'b1);
    repeat (2) cycle();
    chk("preflush_level", 32'(fifo_level), 32'd3);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_level", 32'(fifo_level), 32'd0);
    chk("flush_valid", 32'(bus.cmd_valid), 32'd0);
    chk("flush_held4", 32'(held_out[4]), 32'd1);
    bus.cmd_ready = 1'b1;
    repeat (4) cycle();

    // Button held through reset yields a press after release
    btn_level = 5'b00001;
    rst_n = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    wait_valid(lat);
    chk("btnrst_lat", 32'(lat), 32'd2);
    chk("btnrst_head", 32'(obs_head), 32'h8);
    repeat (3) cycle();

    // Drop counter saturation
    bus.cmd_ready = 1'b0;
    for (int i = 0; i < 320; i++) key(kcodes[i % 8], 1'(i % 2));
    chk("drop_sat", 32'(drop_count), 32'd255);
    do_reset();
    chk("drop_rst", 32'(drop_count), 32'd0);
    btn_level = '0; bus.cmd_ready = 1'b1;
    repeat (5) cycle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int b;
      bus.kb_valid     = ($urandom_range(0, 9) < 3);
      bus.kb_scan_code = acodes[$urandom_range(0, 9)];
      bus.kb_make      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        b = int'($urandom_range(0, 4));
        btn_level[b] = ~btn_level[b];
      end
      bus.cmd_ready = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 99) == 0);
      rst_n         = !($urandom_range(0, 999) == 0);
      cycle();
    end
    bus.kb_valid = 1'b0; flush = 1'b0; rst_n = 1'b1; bus.cmd_ready = 1'b1;
    repeat (20) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
